// File: rtl/sc_sng_bank.sv
// Multi-channel stochastic number generator bank: one shared Fibonacci LFSR,
// per-channel rotated comparators, delayed-bit taps and saturating ones-counters.
module sc_sng_bank #(
  parameter int              WIDTH       = 8,
  parameter int              CHANNELS    = 4,
  parameter int              DELAY_DEPTH = 2,
  parameter int              LEN_W       = 9,
  parameter logic [WIDTH-1:0] TAPS       = 8'b0111_0001,
  parameter int              ROT_STEP    = 1,
  parameter logic [WIDTH-1:0] INV_MASK   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WIDTH-1:0]             seed,
  input  logic [LEN_W-1:0]             len,
  input  logic [CHANNELS*WIDTH-1:0]    b_in,
  output logic                         busy,
  output logic                         bit_valid,
  output logic [CHANNELS-1:0]          bit_out,
  output logic [CHANNELS*DELAY_DEPTH-1:0] bit_dly,
  output logic                         done,
  output logic [CHANNELS*LEN_W-1:0]    ones_cnt,
  output logic [WIDTH-1:0]             lfsr_state
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | operands latched, one setup cycle
  // RUN    | one stochastic bit per cycle until remaining count hits zero
  // DONE   | done pulse; accepts start for back-to-back streams
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] SEED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                               state;
  logic [WIDTH-1:0]                     lfsr;
  logic [LEN_W-1:0]                     rem;
  logic [CHANNELS-1:0][WIDTH-1:0]       b_lat;
  logic [CHANNELS-1:0][LEN_W-1:0]       cnt;
  logic [CHANNELS-1:0][DELAY_DEPTH-1:0] dly;
  logic [2*WIDTH-1:0]                   dbl;
  logic [WIDTH-1:0]                     scr;
  logic [CHANNELS-1:0]                  cmp;
  logic                                 fb;

  assign fb         = ^(lfsr & TAPS);
  assign lfsr_state = lfsr;
  assign ones_cnt   = cnt;
  assign bit_dly    = dly;

  // Rotate-left via the upper half of a doubled word shifted left.
  always_comb begin
    dbl = '0;
    scr = '0;
    cmp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      dbl    = {lfsr, lfsr} << ((i * ROT_STEP) % WIDTH);
      scr    = dbl[2*WIDTH-1 -: WIDTH] ^ INV_MASK;
      cmp[i] = (scr < b_lat[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= '0;
      rem       <= '0;
      b_lat     <= '0;
      cnt       <= '0;
      dly       <= '0;
      bit_out   <= '0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_LOAD;
            lfsr  <= (seed == '0) ? SEED_ONE : seed;
            rem   <= len;
            b_lat <= b_in;
            cnt   <= '0;
            dly   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (rem == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (rem != '0) begin
            bit_out   <= cmp;
            bit_valid <= 1'b1;
            lfsr      <= {fb, lfsr[WIDTH-1:1]};
            rem       <= rem - 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
              if (cmp[i] && (cnt[i] != '1))
                cnt[i] <= cnt[i] + 1'b1;
              // The first bit of a stream has no predecessor to shift in.
              if (bit_valid) begin
                for (int k = DELAY_DEPTH - 1; k > 0; k--)
                  dly[i][k] <= dly[i][k-1];
                dly[i][0] <= bit_out[i];
              end
            end
          end else begin
            bit_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_sng_bank.sv
// Self-checking bench for sc_sng_bank: a stream-level reference model predicts
// every valid bit, tap, ones count and LFSR state from the generator rules.
module tb_sc_sng_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  seed;
  logic [8:0]  len;
  logic [31:0] b_in;
  logic        busy, bit_valid, done;
  logic [3:0]  bit_out;
  logic [7:0]  bit_dly;
  logic [35:0] ones_cnt;
  logic [7:0]  lfsr_state;

  logic        start2;
  logic [7:0]  seed2;
  logic [3:0]  len2;
  logic [31:0] b2;
  logic        busy2, bv2, done2;
  logic [3:0]  bo2;
  logic [7:0]  bd2;
  logic [15:0] oc2;
  logic [7:0]  ls2;

  int n_checks = 0;
  int n_fail   = 0;

  sc_sng_bank dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .len(len), .b_in(b_in),
    .busy(busy), .bit_valid(bit_valid), .bit_out(bit_out), .bit_dly(bit_dly),
    .done(done), .ones_cnt(ones_cnt), .lfsr_state(lfsr_state)
  );

  sc_sng_bank #(.LEN_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .len(len2), .b_in(b2),
    .busy(busy2), .bit_valid(bv2), .bit_out(bo2), .bit_dly(bd2),
    .done(done2), .ones_cnt(oc2), .lfsr_state(ls2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic [7:0] r;
    r = s >> 1;
    if (($countones(s & 8'h71) % 2) == 1) r = r | 8'h80;
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] s, input int r);
    logic [15:0] d;
    d = {s, s} << (r % 8);
    return d[15:8];
  endfunction

  // Caller is at a negedge with the DUT idle or in its done cycle.
  // Returns at the negedge of the done cycle (or one cycle later if idle_after).
  task automatic run_stream(input logic [7:0] sd, input int ln, input logic [31:0] bv,
                            input bit poke, input bit idle_after, input string name);
    logic [7:0]  l [0:512];
    logic [3:0]  eb [0:511];
    int          cnt [4];
    logic [35:0] eo;
    logic [7:0]  edly;
    l[0] = (sd == 8'h00) ? 8'h01 : sd;
    for (int j = 0; j < ln; j++) begin
      for (int ch = 0; ch < 4; ch++) eb[j][ch] = (rotl(l[j], ch) < bv[ch*8 +: 8]);
      l[j+1] = lfsr_next(l[j]);
    end
    for (int ch = 0; ch < 4; ch++) cnt[ch] = 0;
    eo = '0;

    start = 1'b1; seed = sd; len = 9'(ln); b_in = bv;
    @(negedge clk);
    start = poke ? 1'(($urandom_range(0, 1))) : 1'b0;
    seed = 8'($urandom); len = 9'($urandom); b_in = $urandom;
    n_checks++;
    if ({busy, bit_valid, done} !== 3'b100) begin
      n_fail++; $display("FAIL %s load flags: got %b want 100", name, {busy, bit_valid, done});
    end
    n_checks++;
    if (ones_cnt !== 36'd0 || bit_dly !== 8'd0) begin
      n_fail++; $display("FAIL %s load clear: ones %h dly %h want 0", name, ones_cnt, bit_dly);
    end
    @(negedge clk);
    start = poke ? 1'(($urandom_range(0, 1))) : 1'b0;
    seed = 8'($urandom);
    if (ln == 0) begin
      start = 1'b0;
      n_checks++;
      if ({busy, bit_valid, done} !== 3'b001) begin
        n_fail++; $display("FAIL %s len0 done flags: got %b want 001", name, {busy, bit_valid, done});
      end
      n_checks++;
      if (ones_cnt !== 36'd0) begin
        n_fail++; $display("FAIL %s len0 ones: got %h want 0", name, ones_cnt);
      end
    end else begin
      n_checks++;
      if ({busy, bit_valid, done} !== 3'b100 || lfsr_state !== l[0]) begin
        n_fail++; $display("FAIL %s pre-run: flags %b lfsr %h want 100 %h", name,
                           {busy, bit_valid, done}, lfsr_state, l[0]);
      end
      for (int j = 0; j < ln; j++) begin
        @(negedge clk);
        start = (poke && j < ln - 1) ? 1'(($urandom_range(0, 1))) : 1'b0;
        seed = 8'($urandom); len = 9'($urandom);
        for (int ch = 0; ch < 4; ch++) begin
          if (eb[j][ch]) cnt[ch] = (cnt[ch] < 511) ? cnt[ch] + 1 : 511;
          eo[ch*9 +: 9] = 9'(cnt[ch]);
          for (int k = 0; k < 2; k++)
            if (j >= k + 1) edly[ch*2 + k] = eb[j-k-1][ch];
            else            edly[ch*2 + k] = 1'b0;
        end
        n_checks++;
        if ({busy, bit_valid, done} !== 3'b110) begin
          n_fail++; $display("FAIL %s run flags bit %0d: got %b want 110", name, j, {busy, bit_valid, done});
        end
        n_checks++;
        if (bit_out !== eb[j]) begin
          n_fail++; $display("FAIL %s bit_out %0d: got %b want %b", name, j, bit_out, eb[j]);
        end
        n_checks++;
        if (bit_dly !== edly) begin
          n_fail++; $display("FAIL %s bit_dly %0d: got %b want %b", name, j, bit_dly, edly);
        end
        n_checks++;
        if (lfsr_state !== l[j+1]) begin
          n_fail++; $display("FAIL %s lfsr %0d: got %h want %h", name, j, lfsr_state, l[j+1]);
        end
        n_checks++;
        if (ones_cnt !== eo) begin
          n_fail++; $display("FAIL %s ones_cnt %0d: got %h want %h", name, j, ones_cnt, eo);
        end
      end
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({busy, bit_valid, done} !== 3'b001) begin
        n_fail++; $display("FAIL %s done flags: got %b want 001", name, {busy, bit_valid, done});
      end
      n_checks++;
      if (ones_cnt !== eo || bit_out !== eb[ln-1]) begin
        n_fail++; $display("FAIL %s done hold: ones %h bit %b want %h %b", name, ones_cnt, bit_out, eo, eb[ln-1]);
      end
    end
    if (idle_after) begin
      @(negedge clk);
      n_checks++;
      if ({busy, bit_valid, done} !== 3'b000 || ones_cnt !== eo) begin
        n_fail++; $display("FAIL %s idle after: flags %b ones %h want 000 %h", name,
                           {busy, bit_valid, done}, ones_cnt, eo);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; seed = 8'hA5; len = 9'd7; b_in = 32'hFFFF_FFFF;
    start2 = 1'b0; seed2 = 8'h01; len2 = 4'd0; b2 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, bit_valid, done, bit_out, bit_dly, ones_cnt, lfsr_state} !== '0) begin
      n_fail++; $display("FAIL reset outputs: busy %b valid %b done %b bits %b dly %b ones %h lfsr %h want all 0",
                         busy, bit_valid, done, bit_out, bit_dly, ones_cnt, lfsr_state);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({busy, bit_valid, done} !== 3'b000) begin
        n_fail++; $display("FAIL reset idle: flags %b want 000", {busy, bit_valid, done});
      end
    end
  endtask

  task automatic test_lfsr_seq();
    run_stream(8'h01, 3, $urandom, 1'b0, 1'b1, "lfsr_seq");
  endtask

  task automatic test_full_period();
    run_stream(8'h01, 255, {8'd0, 8'd1, 8'd128, 8'd255}, 1'b0, 1'b0, "full_period");
    n_checks++;
    if (ones_cnt !== {9'd0, 9'd0, 9'd127, 9'd254}) begin
      n_fail++; $display("FAIL full_period ones: got %h want {0,0,127,254}", ones_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_len_zero();
    run_stream(8'h3C, 0, $urandom, 1'b0, 1'b1, "len_zero");
  endtask

  task automatic test_seed_zero();
    run_stream(8'h00, 5, $urandom, 1'b0, 1'b1, "seed_zero");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      run_stream(8'($urandom), $urandom_range(0, 40), $urandom, 1'b0, 1'b1, "random");
  endtask

  task automatic test_busy_ignore();
    for (int n = 0; n < 3; n++)
      run_stream(8'($urandom), $urandom_range(1, 30), $urandom, 1'b1, 1'b1, "busy_ignore");
  endtask

  task automatic test_back_to_back();
    run_stream(8'($urandom), 12, $urandom, 1'b0, 1'b0, "b2b_first");
    run_stream(8'($urandom), 9, $urandom, 1'b0, 1'b0, "b2b_second");
    run_stream(8'($urandom), 0, $urandom, 1'b0, 1'b1, "b2b_third");
  endtask

  task automatic test_abort();
    start = 1'b1; seed = 8'($urandom); len = 9'd50; b_in = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bit_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort pre: valid %b busy %b want 1 1", bit_valid, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, bit_valid, done, bit_out, bit_dly, ones_cnt, lfsr_state} !== '0) begin
      n_fail++; $display("FAIL abort clear: busy %b valid %b done %b ones %h lfsr %h want all 0",
                         busy, bit_valid, done, ones_cnt, lfsr_state);
    end
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (60) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0) seen++;
      end
      n_checks++;
      if (seen != 0) begin
        n_fail++; $display("FAIL abort quiet: active cycles %0d want 0", seen);
      end
    end
  endtask

  task automatic test_saturation();
    int nvalid;
    int k;
    start2 = 1'b1; seed2 = 8'h01; len2 = 4'd15; b2 = {4{8'hFF}};
    @(negedge clk);
    start2 = 1'b0;
    nvalid = 0;
    k = 0;
    while (done2 !== 1'b1 && k < 40) begin
      @(negedge clk);
      if (bv2 === 1'b1) nvalid++;
      k++;
    end
    n_checks++;
    if (done2 !== 1'b1) begin
      n_fail++; $display("FAIL saturation timeout: done2 %b after %0d cycles want 1", done2, k);
    end
    n_checks++;
    if (nvalid != 15) begin
      n_fail++; $display("FAIL saturation valid count: got %0d want 15", nvalid);
    end
    n_checks++;
    if (oc2 !== {4{4'd15}}) begin
      n_fail++; $display("FAIL saturation ones: got %h want ffff", oc2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lfsr_seq();
    test_full_period();
    test_len_zero();
    test_seed_zero();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
